// File: rtl/pwm_duty_decoder_if.sv
// Signal bundle between a PWM line source and the duty decoder:
// the sampled line plus the decoded duty/period results.
interface pwm_duty_decoder_if #(
  parameter int CW = 6
);
  logic          Pulse_In;
  logic [CW-1:0] Duty;
  logic [CW:0]   Period_Len;
  logic          Duty_Valid;
  logic          No_Edge;
  logic          Locked;

  // Source side: drives the PWM line, observes decoded results
  modport master (
    output Pulse_In,
    input  Duty, Period_Len, Duty_Valid, No_Edge, Locked
  );

  // Decoder side: samples the PWM line, produces decoded results
  modport slave (
    input  Pulse_In,
    output Duty, Period_Len, Duty_Valid, No_Edge, Locked
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: synchronizes a PWM line, measures high-sample count and
// length of each window between rising edges (capped at PERIOD samples),
// and tracks lock to the transmitter's period boundary.
module pwm_duty_decoder #(
  parameter int PERIOD       = 64,
  parameter int CW           = 6,
  parameter int LOSS_WINDOWS = 8
) (
  input  logic              sysclk,
  input  logic              Reset,
  pwm_duty_decoder_if.slave pwm
);

  localparam logic [CW:0] PERIOD_W = (CW+1)'(PERIOD);
  localparam logic [3:0]  LOSS_LIM = 4'(LOSS_WINDOWS);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_d;

  logic          sync1;
  logic          sync2;
  logic          s_prev;
  logic [CW:0]   win_cnt;
  logic [CW:0]   high_cnt;
  logic [3:0]    loss_cnt;
  logic [3:0]    loss_d;

  logic          rise;
  logic          edge_close;
  logic          limit_close;
  logic          close;
  logic          emit;

  logic [CW-1:0] duty_p0;
  logic [CW:0]   period_len_p0;
  logic          no_edge_p0;
  logic          vld_p0;

  // A full window of high samples (count == 2**CW) does not fit in CW bits;
  // clamp it to the largest representable duty.
  function automatic logic [CW-1:0] sat_duty(input logic [CW:0] cnt);
    if (cnt[CW]) begin
      return '1;
    end
    return cnt[CW-1:0];
  endfunction

  // Two-flop synchronizer plus one-cycle history for edge detection
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      s_prev <= 1'b1;
    end else begin
      sync1  <= pwm.Pulse_In;
      sync2  <= sync1;
      s_prev <= sync2;
    end
  end

  // Close detection and lock FSM next-state / emit decision
  always_comb begin
    rise        = sync2 & ~s_prev;
    edge_close  = rise && (win_cnt != '0);
    limit_close = !rise && (win_cnt == PERIOD_W);
    close       = edge_close || limit_close;
    state_d     = state;
    loss_d      = loss_cnt;
    emit        = 1'b0;
    case (state)
      UNLOCKED: begin
        if (edge_close) begin
          // Partial window since the last arbitrary boundary is dropped.
          state_d = LOCKED;
          loss_d  = '0;
        end else if (limit_close) begin
          emit = 1'b1;
        end
      end
      LOCKED: begin
        if (edge_close) begin
          emit   = 1'b1;
          loss_d = '0;
        end else if (limit_close) begin
          emit = 1'b1;
          if (loss_cnt + 4'd1 == LOSS_LIM) begin
            state_d = UNLOCKED;
            loss_d  = '0;
          end else begin
            loss_d = loss_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_d = UNLOCKED;
        loss_d  = '0;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      state    <= UNLOCKED;
      loss_cnt <= '0;
    end else begin
      state    <= state_d;
      loss_cnt <= loss_d;
    end
  end

  // Window accumulation; a close restarts the window with the current sample
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      win_cnt  <= '0;
      high_cnt <= '0;
    end else if (close) begin
      win_cnt  <= (CW+1)'(1);
      high_cnt <= {{CW{1'b0}}, sync2};
    end else begin
      win_cnt  <= win_cnt + (CW+1)'(1);
      high_cnt <= high_cnt + {{CW{1'b0}}, sync2};
    end
  end

  // Result registers: strobe every emitted close, hold values between strobes
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      vld_p0        <= 1'b0;
      duty_p0       <= '0;
      period_len_p0 <= '0;
      no_edge_p0    <= 1'b0;
    end else begin
      vld_p0 <= emit;
      if (emit) begin
        duty_p0       <= sat_duty(high_cnt);
        period_len_p0 <= win_cnt;
        no_edge_p0    <= limit_close;
      end
    end
  end

  assign pwm.Duty       = duty_p0;
  assign pwm.Period_Len = period_len_p0;
  assign pwm.Duty_Valid = vld_p0;
  assign pwm.No_Edge    = no_edge_p0;
  assign pwm.Locked     = (state == LOCKED);

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: directed PWM patterns plus random periods,
// checked by a window-queue reference model through an expected-strobe queue.
module tb_pwm_duty_decoder;

  localparam int PERIOD       = 64;
  localparam int CW           = 6;
  localparam int LOSS_WINDOWS = 8;

  logic sysclk;
  logic Reset;

  pwm_duty_decoder_if #(.CW(CW)) bus ();

  pwm_duty_decoder #(
    .PERIOD       (PERIOD),
    .CW           (CW),
    .LOSS_WINDOWS (LOSS_WINDOWS)
  ) dut (
    .sysclk (sysclk),
    .Reset  (Reset),
    .pwm    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int duty;
    int len;
    bit no_edge;
  } exp_t;

  exp_t exp_q[$];
  bit   m_d1, m_d2, m_prev;
  bit   m_win[$];
  bit   m_locked;
  int   m_loss;
  bit   m_s, m_rise, m_by_edge, m_close, m_emit;
  int   m_ones;
  exp_t m_e;

  initial begin
    m_d1 = 0; m_d2 = 0; m_prev = 1; m_locked = 0; m_loss = 0;
  end

  // Window = list of samples since the last boundary; duty = number of ones.
  always @(posedge sysclk) begin
    if (Reset) begin
      m_d1 = 0; m_d2 = 0; m_prev = 1;
      m_win.delete();
      m_locked = 0;
      m_loss = 0;
    end else begin
      m_s       = m_d2;
      m_rise    = m_s && !m_prev;
      m_by_edge = m_rise && (m_win.size() > 0);
      m_close   = m_by_edge || (m_win.size() == PERIOD);
      if (m_close) begin
        m_ones = 0;
        foreach (m_win[i]) m_ones += int'(m_win[i]);
        m_e.duty    = (m_ones > (1 << CW) - 1) ? (1 << CW) - 1 : m_ones;
        m_e.len     = m_win.size();
        m_e.no_edge = !m_by_edge;
        m_emit = 1;
        if (!m_locked) begin
          if (m_by_edge) begin
            m_locked = 1;
            m_loss = 0;
            m_emit = 0;
          end
        end else if (m_by_edge) begin
          m_loss = 0;
        end else begin
          m_loss++;
          if (m_loss == LOSS_WINDOWS) begin
            m_locked = 0;
            m_loss = 0;
          end
        end
        if (m_emit) exp_q.push_back(m_e);
        m_win.delete();
      end
      m_win.push_back(m_s);
      m_prev = m_s;
      m_d2 = m_d1;
      m_d1 = bus.Pulse_In;
    end
  end

  // ---------------- monitor ----------------
  bit   started = 0;
  int   n_strobes = 0;
  int   last_duty, last_len;
  bit   last_no_edge;
  exp_t m_got;

  always @(negedge sysclk) begin
    if (started) begin
      chk("locked", int'(bus.Locked), int'(m_locked));
      if (bus.Duty_Valid) begin
        n_strobes++;
        last_duty    = int'(bus.Duty);
        last_len     = int'(bus.Period_Len);
        last_no_edge = bus.No_Edge;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          m_got = exp_q.pop_front();
          chk("duty", int'(bus.Duty), m_got.duty);
          chk("period_len", int'(bus.Period_Len), m_got.len);
          chk("no_edge", int'(bus.No_Edge), int'(m_got.no_edge));
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        chk("missing_strobe", 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_state();
    chk("rst_duty", int'(bus.Duty), 0);
    chk("rst_period_len", int'(bus.Period_Len), 0);
    chk("rst_duty_valid", int'(bus.Duty_Valid), 0);
    chk("rst_no_edge", int'(bus.No_Edge), 0);
    chk("rst_locked", int'(bus.Locked), 0);
  endtask

  // One PWM period of 'per' cycles, high for the first 'hi'; optional
  // one-cycle reset at cycle index rst_at (negative = none).
  task automatic pwm_period(input int per, input int hi, input int rst_at);
    for (int i = 0; i < per; i++) begin
      bus.Pulse_In = (i < hi);
      Reset = (i == rst_at);
      @(negedge sysclk);
      if (i == rst_at) check_reset_state();
    end
    Reset = 1'b0;
  endtask

  int sweep[$];
  int per, hi, ra;

  initial begin
    Reset = 1'b1;
    bus.Pulse_In = 1'b0;
    repeat (3) @(negedge sysclk);
    check_reset_state();
    started = 1;
    n_strobes = 0;
    Reset = 1'b0;

    // Line low: limit closes every 64 cycles, never locks
    repeat (300) @(negedge sysclk);
    #1;
    chk("low_strobe_count", n_strobes, 4);
    chk("low_duty", last_duty, 0);
    chk("low_len", last_len, 64);
    chk("low_no_edge", int'(last_no_edge), 1);

    // 64-cycle PWM, high 20
    repeat (6) pwm_period(64, 20, -1);
    #1;
    chk("pwm20_duty", last_duty, 20);
    chk("pwm20_len", last_len, 64);
    chk("pwm20_no_edge", int'(last_no_edge), 0);
    chk("pwm20_locked", int'(bus.Locked), 1);

    // 63/64 high, then held high until lock is lost
    repeat (4) pwm_period(64, 63, -1);
    bus.Pulse_In = 1'b1;
    repeat (12 * 64) @(negedge sysclk);
    #1;
    chk("high_duty_sat", last_duty, 63);
    chk("high_len", last_len, 64);
    chk("high_no_edge", int'(last_no_edge), 1);
    chk("high_unlocked", int'(bus.Locked), 0);

    // 40-cycle period, high 10
    repeat (6) pwm_period(40, 10, -1);
    #1;
    chk("p40_duty", last_duty, 10);
    chk("p40_len", last_len, 40);
    chk("p40_no_edge", int'(last_no_edge), 0);
    chk("p40_locked", int'(bus.Locked), 1);

    // Duty sweep up and down, looped twice
    for (int k = 0; k <= 6; k++) begin
      sweep.push_back((1 << k) - 1);
      sweep.push_back((1 << k) - 1);
    end
    sweep.push_back(63);
    sweep.push_back(63);
    for (int k = 5; k >= 0; k--) begin
      sweep.push_back((1 << k) - 1);
      sweep.push_back((1 << k) - 1);
    end
    repeat (2) foreach (sweep[i]) pwm_period(64, sweep[i], -1);
    #1;
    chk("sweep_locked", int'(bus.Locked), 1);

    // Reset pulse mid-window, then re-acquire
    repeat (2) pwm_period(64, 20, -1);
    pwm_period(64, 20, 30);
    repeat (3) pwm_period(64, 20, -1);
    #1;
    chk("rst_mid_duty", last_duty, 20);
    chk("rst_mid_len", last_len, 64);
    chk("rst_mid_locked", int'(bus.Locked), 1);

    // Random periods, duties, glitches and occasional resets
    for (int n = 0; n < 80; n++) begin
      per = int'($urandom_range(80, 1));
      hi  = int'($urandom_range(per, 0));
      ra  = ($urandom_range(15, 0) == 0) ? int'($urandom_range(per - 1, 0)) : -1;
      pwm_period(per, hi, ra);
    end
    bus.Pulse_In = 1'b0;
    repeat (4) @(negedge sysclk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
